csr_trap_regfile: RTL and testbench

Parametrised machine-mode CSR file and trap controller for the RV32I core, successor to the single-interrupt CSR block. It holds the writable M-mode CSRs, supports CSRRW/CSRRS/CSRRC semantics, and arbitrates `NUM_IRQ` level interrupt lines by fixed priority. It also runs 64-bit `mcycle`/`minstret` counters and implements vectored or direct trap entry plus `mret` return. It sits beside the decode/execute stage; the pipeline redirects fetch to `trap_pc` when `trap_taken` is high and to `mepc` on `mret`.

---
 rtl/csr_trap_regfile.sv | 196 +++++++++++++++++++
 tb/tb_csr_trap_regfile.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_regfile.sv
// Machine-mode CSR file for the RV32I core: CSRRW/CSRRS/CSRRC access, fixed-priority
// interrupt trap entry (direct or vectored), mret return and 64-bit cycle/instret counters.
module csr_trap_regfile #(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0500,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [11:0]        csr_addr,
   input  logic [1:0]         csr_op,
   input  logic [31:0]        csr_w_data,
   output logic [31:0]        csr_r_data,
   output logic               illegal,
   input  logic [31:0]        pc,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               ret,
   input  logic               retire,
   output logic               trap_taken,
   output logic [31:0]        trap_pc,
   output logic [31:0]        mepc
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
   localparam logic [31:0] MISA_VALUE     = 32'h4000_0100;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic               mstatus_mie_reg;
   logic               mstatus_mpie_reg;
   logic [NUM_IRQ-1:0] mie_reg;
   logic [NUM_IRQ-1:0] mip_reg;
   logic [31:0]        mtvec_reg;
   logic [31:0]        mscratch_reg;
   logic [31:0]        mepc_reg;
   logic [31:0]        mcause_reg;
   logic [31:0]        mtval_reg;
   logic [63:0]        mcycle_reg;
   logic [63:0]        mcycle_next;
   logic [63:0]        minstret_reg;
   logic [63:0]        minstret_next;

   logic [31:0]        mstatus_word;
   logic [31:0]        mie_word;
   logic [31:0]        mip_word;
   logic [31:0]        new_value;
   logic               writable;
   logic               csr_we;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] win_onehot;
   logic [3:0]         win_idx;
   logic [4:0]         win_code;
   logic [31:0]        mtvec_base;

   // MPP is hardwired to machine mode, so it always reads back as 11.
   assign mstatus_word = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
   assign mie_word     = 32'(mie_reg) << 16;
   assign mip_word     = 32'(mip_reg) << 16;

   always_comb begin
      csr_r_data = '0;
      writable   = 1'b0;
      case (csr_addr)
         ADDR_MSTATUS:   begin csr_r_data = mstatus_word;        writable = 1'b1; end
         ADDR_MISA:            csr_r_data = MISA_VALUE;
         ADDR_MIE:       begin csr_r_data = mie_word;            writable = 1'b1; end
         ADDR_MTVEC:     begin csr_r_data = mtvec_reg;           writable = 1'b1; end
         ADDR_MSCRATCH:  begin csr_r_data = mscratch_reg;        writable = 1'b1; end
         ADDR_MEPC:      begin csr_r_data = mepc_reg;            writable = 1'b1; end
         ADDR_MCAUSE:    begin csr_r_data = mcause_reg;          writable = 1'b1; end
         ADDR_MTVAL:     begin csr_r_data = mtval_reg;           writable = 1'b1; end
         ADDR_MIP:             csr_r_data = mip_word;
         ADDR_MCYCLE:    begin csr_r_data = mcycle_reg[31:0];    writable = 1'b1; end
         ADDR_MCYCLEH:   begin csr_r_data = mcycle_reg[63:32];   writable = 1'b1; end
         ADDR_MINSTRET:  begin csr_r_data = minstret_reg[31:0];  writable = 1'b1; end
         ADDR_MINSTRETH: begin csr_r_data = minstret_reg[63:32]; writable = 1'b1; end
         ADDR_MHARTID:         csr_r_data = HART_ID;
         default: ;
      endcase
   end

   always_comb begin
      new_value = csr_r_data;
      case (csr_op)
         OP_WRITE: new_value = csr_w_data;
         OP_SET:   new_value = csr_r_data | csr_w_data;
         OP_CLEAR: new_value = csr_r_data & ~csr_w_data;
         default:  new_value = csr_r_data;
      endcase
   end

   assign illegal = (csr_op != OP_NONE) && !writable;
   assign pend    = mip_reg & mie_reg;

   // Lowest-numbered pending line wins.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_win
         if (gi == 0) begin : g_first
            assign win_onehot[gi] = pend[0];
         end else begin : g_rest
            assign win_onehot[gi] = pend[gi] & ~(|pend[gi-1:0]);
         end
      end
   endgenerate

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (win_onehot[i]) win_idx = win_idx | 4'(i);
      end
   end

   assign win_code   = 5'd16 + {1'b0, win_idx};
   assign trap_taken = mstatus_mie_reg & (|pend) & ~ret;
   assign mtvec_base = {mtvec_reg[31:2], 2'b00};
   assign trap_pc    = mtvec_reg[0] ? (mtvec_base + {25'b0, win_code, 2'b00}) : mtvec_base;
   assign mepc       = mepc_reg;
   // A trap cycle swallows the CSR access entirely, counters included.
   assign csr_we     = (csr_op != OP_NONE) && writable && !trap_taken;

   always_comb begin
      mcycle_next   = mcycle_reg + 64'd1;
      minstret_next = minstret_reg + {63'b0, retire};
      if (csr_we) begin
         case (csr_addr)
            ADDR_MCYCLE:    mcycle_next   = {mcycle_reg[63:32], new_value};
            ADDR_MCYCLEH:   mcycle_next   = {new_value, mcycle_reg[31:0]};
            ADDR_MINSTRET:  minstret_next = {minstret_reg[63:32], new_value};
            ADDR_MINSTRETH: minstret_next = {new_value, minstret_reg[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mstatus_mie_reg  <= 1'b1;
         mstatus_mpie_reg <= 1'b0;
         mie_reg          <= '0;
         mip_reg          <= '0;
         mtvec_reg        <= MTVEC_RESET;
         mscratch_reg     <= '0;
         mepc_reg         <= '0;
         mcause_reg       <= '0;
         mtval_reg        <= '0;
         mcycle_reg       <= '0;
         minstret_reg     <= '0;
      end else begin
         mip_reg      <= irq;
         mcycle_reg   <= mcycle_next;
         minstret_reg <= minstret_next;
         if (ret) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
         end else if (trap_taken) begin
            mepc_reg         <= pc & ~32'd3;
            mcause_reg       <= {1'b1, 26'b0, win_code};
            mtval_reg        <= '0;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
         end else if (csr_we && (csr_addr == ADDR_MSTATUS)) begin
            mstatus_mie_reg  <= new_value[3];
            mstatus_mpie_reg <= new_value[7];
         end
         if (csr_we) begin
            case (csr_addr)
               ADDR_MIE:      mie_reg      <= new_value[16 +: NUM_IRQ];
               ADDR_MTVEC:    mtvec_reg    <= {new_value[31:2], 1'b0, new_value[0]};
               ADDR_MSCRATCH: mscratch_reg <= new_value;
               ADDR_MEPC:     mepc_reg     <= {new_value[31:2], 2'b00};
               ADDR_MCAUSE:   mcause_reg   <= new_value;
               ADDR_MTVAL:    mtval_reg    <= new_value;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csr_trap_regfile.sv
// Directed and randomized bench for csr_trap_regfile, checked every cycle against a
// word-level reference model of the machine-mode CSR and trap rules.
module tb_csr_trap_regfile;

   localparam int NIRQ = 4;
   localparam logic [31:0] IRQ_MASK = ((32'd1 << NIRQ) - 32'd1) << 16;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [11:0]     csr_addr = '0;
   logic [1:0]      csr_op = '0;
   logic [31:0]     csr_w_data = '0;
   logic [31:0]     csr_r_data;
   logic            illegal;
   logic [31:0]     pc = '0;
   logic [NIRQ-1:0] irq = '0;
   logic            ret = 1'b0;
   logic            retire = 1'b0;
   logic            trap_taken;
   logic [31:0]     trap_pc;
   logic [31:0]     mepc;

   always #5 clock = ~clock;

   csr_trap_regfile #(
      .NUM_IRQ(NIRQ),
      .MTVEC_RESET(32'h0000_0500),
      .HART_ID(32'h0000_0000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .csr_addr(csr_addr),
      .csr_op(csr_op),
      .csr_w_data(csr_w_data),
      .csr_r_data(csr_r_data),
      .illegal(illegal),
      .pc(pc),
      .irq(irq),
      .ret(ret),
      .retire(retire),
      .trap_taken(trap_taken),
      .trap_pc(trap_pc),
      .mepc(mepc)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [31:0] obs_rdata;
   logic        obs_illegal;
   logic        obs_trap;
   logic [31:0] obs_tpc;

   // Reference model: every CSR kept as the full 32-bit word software would read.
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
   logic [63:0] m_mcycle, m_minstret;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_mstatus  = 32'h0000_1808;
      m_mie      = '0;
      m_mtvec    = 32'h0000_0500;
      m_mscratch = '0;
      m_mepc     = '0;
      m_mcause   = '0;
      m_mtval    = '0;
      m_mip      = '0;
      m_mcycle   = '0;
      m_minstret = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h301: return 32'h4000_0100;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip;
         12'hB00: return m_mcycle[31:0];
         12'hB80: return m_mcycle[63:32];
         12'hB02: return m_minstret[31:0];
         12'hB82: return m_minstret[63:32];
         12'hF14: return 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_writable(input logic [11:0] a);
      return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                       12'hB00, 12'hB80, 12'hB02, 12'hB82};
   endfunction

   function automatic bit m_illegal();
      return (csr_op != 2'b00) && !m_writable(csr_addr);
   endfunction

   function automatic int m_winner();
      for (int i = 0; i < NIRQ; i++) begin
         if (m_mip[16+i] && m_mie[16+i]) return i;
      end
      return -1;
   endfunction

   function automatic bit m_trap();
      return m_mstatus[3] && ((m_mip & m_mie) != 32'h0) && !ret;
   endfunction

   function automatic logic [31:0] m_tpc();
      int w;
      logic [31:0] base;
      w = m_winner();
      base = m_mtvec & ~32'd3;
      if (m_mtvec[0]) return base + 32'(4 * (16 + w));
      return base;
   endfunction

   task automatic m_update();
      logic [31:0] old, nv;
      bit we, trap;
      int w;
      if (reset) begin
         m_reset();
         return;
      end
      old  = m_read(csr_addr);
      trap = m_trap();
      w    = m_winner();
      case (csr_op)
         2'b01:   nv = csr_w_data;
         2'b10:   nv = old | csr_w_data;
         2'b11:   nv = old & ~csr_w_data;
         default: nv = old;
      endcase
      we = (csr_op != 2'b00) && m_writable(csr_addr) && !trap;

      if (we && csr_addr == 12'hB00)      m_mcycle[31:0]  = nv;
      else if (we && csr_addr == 12'hB80) m_mcycle[63:32] = nv;
      else                                m_mcycle = m_mcycle + 64'd1;
      if (we && csr_addr == 12'hB02)      m_minstret[31:0]  = nv;
      else if (we && csr_addr == 12'hB82) m_minstret[63:32] = nv;
      else if (retire)                    m_minstret = m_minstret + 64'd1;

      if (ret) begin
         m_mstatus = 32'h0000_1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (trap) begin
         m_mepc    = pc & ~32'd3;
         m_mcause  = 32'h8000_0000 | 32'(16 + w);
         m_mtval   = 32'h0;
         m_mstatus = 32'h0000_1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (we && csr_addr == 12'h300) begin
         m_mstatus = 32'h0000_1800 | (nv & 32'h88);
      end

      if (we) begin
         case (csr_addr)
            12'h304: m_mie      = nv & IRQ_MASK;
            12'h305: m_mtvec    = nv & ~32'd2;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc     = nv & ~32'd3;
            12'h342: m_mcause   = nv;
            12'h343: m_mtval    = nv;
            default: ;
         endcase
      end
      m_mip = 32'(irq) << 16;
   endtask

   // One clock cycle: compare at the falling edge, then advance DUT and model together.
   task automatic step();
      @(negedge clock);
      obs_rdata   = csr_r_data;
      obs_illegal = illegal;
      obs_trap    = trap_taken;
      obs_tpc     = trap_pc;
      if (chk_en) begin
         check("csr_r_data", csr_r_data, m_read(csr_addr));
         check("illegal", 32'(illegal), 32'(m_illegal()));
         check("trap_taken", 32'(trap_taken), 32'(m_trap()));
         check("mepc_port", mepc, m_mepc);
         if (m_trap()) check("trap_pc", trap_pc, m_tpc());
      end
      @(posedge clock);
      m_update();
      #1;
   endtask

   task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csr_addr   = a;
      csr_op     = op;
      csr_w_data = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(12'h300, 2'b00, 32'h0);
      step();
      reset = 1'b0;
   endtask

   logic [11:0] ro_addr[13];
   logic [31:0] ro_exp[13];
   logic [11:0] rnd_addr[16];

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_reset();
      ro_addr = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h343, 12'h344, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
      ro_exp  = '{32'h0000_1808, 32'h4000_0100, 32'h0, 32'h0000_0500, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      rnd_addr = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h000};

      // Reset and reset values
      reset = 1'b1;
      step();
      chk_en = 1'b1;
      drive(12'h300, 2'b00, 32'h0);
      step();
      check("reset_mstatus", obs_rdata, 32'h0000_1808);
      reset = 1'b0;
      drive(12'hB00, 2'b00, 32'h0);
      step();
      step();
      check("mcycle_first", obs_rdata, 32'd1);
      step();
      check("mcycle_second", obs_rdata, 32'd2);
      for (int i = 0; i < 13; i++) begin
         drive(ro_addr[i], 2'b00, 32'h0);
         step();
         check($sformatf("reset_read_%h", ro_addr[i]), obs_rdata, ro_exp[i]);
      end

      // CSRRW / CSRRS / CSRRC on mscratch, WARL on mstatus
      drive(12'h340, 2'b01, 32'hA5A5_A5A5); step(); check("rw_old", obs_rdata, 32'h0);
      drive(12'h340, 2'b10, 32'h0000_000F); step(); check("rs_old", obs_rdata, 32'hA5A5_A5A5);
      drive(12'h340, 2'b11, 32'h0000_00A0); step(); check("rc_old", obs_rdata, 32'hA5A5_A5AF);
      drive(12'h340, 2'b00, 32'h0);         step(); check("rc_new", obs_rdata, 32'hA5A5_A50F);
      drive(12'h300, 2'b01, 32'hFFFF_FFFF); step();
      drive(12'h300, 2'b00, 32'h0);         step(); check("mstatus_warl", obs_rdata, 32'h0000_1888);

      // Direct-mode trap
      do_reset();
      drive(12'h304, 2'b01, 32'h0003_0000); step();
      irq = 4'b0110; pc = 32'h0000_0124;
      drive(12'h300, 2'b00, 32'h0); step(); check("direct_not_yet", 32'(obs_trap), 32'd0);
      step();
      check("direct_taken", 32'(obs_trap), 32'd1);
      check("direct_tpc", obs_tpc, 32'h0000_0500);
      drive(12'h341, 2'b00, 32'h0); step();
      check("direct_mepc", obs_rdata, 32'h0000_0124);
      check("no_back_to_back", 32'(obs_trap), 32'd0);
      drive(12'h342, 2'b00, 32'h0); step(); check("direct_mcause", obs_rdata, 32'h8000_0011);
      drive(12'h300, 2'b00, 32'h0); step(); check("direct_mstatus", obs_rdata, 32'h0000_1880);
      irq = '0;

      // Vectored-mode trap, mret, re-fire
      do_reset();
      drive(12'h304, 2'b01, 32'h0003_0000); step();
      drive(12'h305, 2'b01, 32'h0000_0501); step();
      irq = 4'b0110;
      drive(12'h300, 2'b00, 32'h0); step();
      step();
      check("vec_taken", 32'(obs_trap), 32'd1);
      check("vec_tpc", obs_tpc, 32'h0000_0544);
      ret = 1'b1; step();
      ret = 1'b0; step();
      check("mret_mstatus", obs_rdata, 32'h0000_1888);
      check("refire", 32'(obs_trap), 32'd1);
      irq = '0; step();

      // ret with pending interrupt, CSR write dropped in trap cycle, illegal address
      do_reset();
      drive(12'h304, 2'b01, 32'h0003_0000); step();
      drive(12'h300, 2'b01, 32'h0000_0088); step();
      irq = 4'b0110;
      drive(12'h300, 2'b00, 32'h0); step();
      ret = 1'b1; step(); check("ret_blocks_trap", 32'(obs_trap), 32'd0);
      ret = 1'b0;
      drive(12'h340, 2'b01, 32'hDEAD_BEEF); step(); check("delayed_trap", 32'(obs_trap), 32'd1);
      drive(12'h340, 2'b00, 32'h0); step(); check("write_dropped", obs_rdata, 32'h0);
      irq = '0;
      drive(12'h7C0, 2'b01, 32'h0000_1000); step();
      check("illegal_addr", 32'(obs_illegal), 32'd1);
      check("illegal_read", obs_rdata, 32'h0);
      drive(12'h301, 2'b01, 32'h0); step(); check("illegal_ro", 32'(obs_illegal), 32'd1);

      // Counter wrap and instret
      drive(12'hB00, 2'b01, 32'hFFFF_FFFF); step();
      drive(12'hB80, 2'b01, 32'hFFFF_FFFF); step();
      drive(12'hB00, 2'b00, 32'h0); step();
      step(); check("mcycle_wrap_lo", obs_rdata, 32'h0);
      drive(12'hB80, 2'b00, 32'h0); step(); check("mcycle_wrap_hi", obs_rdata, 32'h0);
      drive(12'hB02, 2'b01, 32'h0); step();
      drive(12'hB82, 2'b01, 32'h0); step();
      drive(12'hB02, 2'b00, 32'h0);
      retire = 1'b1;
      for (int i = 0; i < 10; i++) step();
      retire = 1'b0; step(); check("minstret_10", obs_rdata, 32'd10);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset      = ($urandom_range(0, 39) == 0);
         csr_addr   = rnd_addr[$urandom_range(0, 15)];
         csr_op     = 2'($urandom);
         csr_w_data = $urandom();
         pc         = $urandom();
         if ($urandom_range(0, 3) == 0) irq = NIRQ'($urandom());
         ret        = ($urandom_range(0, 7) == 0);
         retire     = 1'($urandom);
         step();
      end
      reset = 1'b0; ret = 1'b0; irq = '0;
      drive(12'h300, 2'b00, 32'h0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
